// File: rtl/mbist_pkg.sv
// March C- element tables and state/op encodings shared by the BIST controller.
// Pure definitions: no logic, no latency.
package mbist_pkg;

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} march_state_t;
  typedef enum logic {OP_R, OP_W} march_op_t;

  // Bit i describes element Mi; bits 6-7 pad the tables so any state indexes safely.
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
  localparam logic [7:0] ELEM_RBG    = 8'b0001_0100;
  localparam logic [7:0] ELEM_WBG    = 8'b0000_1010;
  localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;

  function automatic logic [2:0] elem_idx(input march_state_t s);
    logic [3:0] d;
    d = 4'(s) - 4'(M0);
    return d[2:0];
  endfunction

  function automatic march_op_t first_op(input march_state_t s);
    return (s == M0) ? OP_W : OP_R;
  endfunction

endpackage

// File: rtl/march_controller_if.sv
// Control/result and memory-side bus between the March engine and its environment.
// Wires only; master is the controller side.
interface march_controller_if #(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [WIDTH-1:0]  mem_rdata;
  logic              Nbart;
  logic [ADDR_W-1:0] bist_addr;
  logic [WIDTH-1:0]  bist_wdata;
  logic              bist_we;
  logic              bist_re;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;

  modport master (
    input  start, mem_rdata,
    output Nbart, bist_addr, bist_wdata, bist_we, bist_re, busy, done, fail, fail_addr
  );

  modport slave (
    output start, mem_rdata,
    input  Nbart, bist_addr, bist_wdata, bist_we, bist_re, busy, done, fail, fail_addr
  );
endinterface

// File: rtl/march_addr_gen.sv
// Up/down address counter: load to first address of an element, step, terminal flag.
// Address is registered; term is decoded from the registered address and direction.
module march_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              term
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign term = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/march_controller.sv
// March C- BIST engine: one memory op per cycle, read checked the cycle after bist_re.
// Run is 10*DEPTH op cycles plus one flush cycle; start is ignored while busy.
module march_controller
  import mbist_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  march_controller_if.master bus
);

  march_state_t      state, nxt_state;
  march_op_t         nxt_op;
  logic              ph, nxt_ph;
  logic              ag_load, ag_load_down, ag_step, ag_term;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        idx, nxt_idx, load_idx;
  logic              in_elem, start_ok;
  logic              nbart_q, we_q, re_q, busy_q, done_q, fail_q;
  logic [WIDTH-1:0]  wdata_q, chk_exp;
  logic [ADDR_W-1:0] fail_addr_q, chk_addr;
  logic              chk_vld;

  assign idx      = elem_idx(state);
  assign nxt_idx  = elem_idx(nxt_state);
  assign load_idx = idx + 3'd1;
  assign start_ok = (state == IDLE || state == DONE) && bus.start;
  assign in_elem  = nxt_state inside {M0, M1, M2, M3, M4, M5};

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (ELEM_DOWN[idx]),
    .addr      (addr),
    .term      (ag_term)
  );

  always_comb begin
    nxt_state    = state;
    nxt_ph       = 1'b0;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    nxt_op       = OP_R;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          nxt_state    = M0;
          ag_load      = 1'b1;
          ag_load_down = ELEM_DOWN[0];
        end
      end
      FLUSH: nxt_state = DONE;
      default: begin
        // Two-op elements read then write the same address before moving on.
        if (ELEM_TWO_OP[idx] && !ph) begin
          nxt_ph = 1'b1;
        end else if (!ag_term) begin
          ag_step = 1'b1;
        end else if (state == M5) begin
          nxt_state = FLUSH;
        end else begin
          nxt_state    = march_state_t'(4'(state) + 4'd1);
          ag_load      = 1'b1;
          ag_load_down = ELEM_DOWN[load_idx];
        end
      end
    endcase
    if (ELEM_TWO_OP[nxt_idx]) nxt_op = nxt_ph ? OP_W : OP_R;
    else                      nxt_op = first_op(nxt_state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ph          <= 1'b0;
      nbart_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wdata_q     <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      chk_vld     <= 1'b0;
      chk_exp     <= '0;
      chk_addr    <= '0;
    end else begin
      state   <= nxt_state;
      ph      <= nxt_ph;
      nbart_q <= (nxt_state != IDLE) && (nxt_state != DONE);
      busy_q  <= (nxt_state != IDLE) && (nxt_state != DONE);
      done_q  <= (nxt_state == DONE);
      we_q    <= in_elem && (nxt_op == OP_W);
      re_q    <= in_elem && (nxt_op == OP_R);
      wdata_q <= in_elem ? {WIDTH{ELEM_WBG[nxt_idx]}} : '0;
      // Capture what the read issued this cycle must return next cycle.
      chk_vld  <= re_q;
      chk_exp  <= {WIDTH{ELEM_RBG[idx]}};
      chk_addr <= addr;
      if (start_ok) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
      end else if (chk_vld && (bus.mem_rdata != chk_exp)) begin
        fail_q <= 1'b1;
        if (!fail_q) fail_addr_q <= chk_addr;
      end
    end
  end

  assign bus.Nbart      = nbart_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bist_we    = we_q;
  assign bus.bist_re    = re_q;
  assign bus.bist_wdata = wdata_q;
  assign bus.bist_addr  = addr;
  assign bus.fail       = fail_q;
  assign bus.fail_addr  = fail_addr_q;

endmodule

// File: doc/march_controller.md
# march_controller

Sequential March C- engine for the memory built-in self-test path. On `start` it takes over the memory by raising `Nbart` and drives address, write data and read/write strobes into the `bist_in` side of the multiplexers. It checks every read against the expected background and reports pass/fail plus the first failing address. It sits directly upstream of the normal/BIST multiplexers, and its `Nbart` output is their select line.

## Interface
- `WIDTH`, 10, memory word width in bits
- `ADDR_W`, 4, address width; DEPTH = 2**ADDR_W words tested
- `clk` in 1, sole clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `start` in 1, single-cycle request to run a test
- `mem_rdata` in WIDTH, memory read data, valid one cycle after `bist_re`
- `Nbart` out 1, 1 = BIST path selected at the multiplexers, 0 = normal path
- `bist_addr` out ADDR_W, address to memory via multiplexer
- `bist_wdata` out WIDTH, write data (all-0 or all-1 background)
- `bist_we` out 1, write strobe
- `bist_re` out 1, read strobe
- `busy` out 1, test in progress
- `done` out 1, test finished; held until next `start` or reset
- `fail` out 1, sticky mismatch flag, valid when `done`=1
- `fail_addr` out ADDR_W, address of the first mismatch; 0 if none

## Operation
- Sequence of March elements:
  - M0 ⇕(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇕(r0)
  - ⇕ executes ascending.
- FSM states: IDLE → M0 → M1 → M2 → M3 → M4 → M5 → FLUSH → DONE. DONE → M0 on `start`. IDLE/DONE ignore nothing else.
- Operation timing and addressing:
  - One operation per cycle. Two-op elements spend 2 cycles per address (read then write, same address).
  - Ascending elements run 0..DEPTH-1. Descending elements run DEPTH-1..0.
  - The element advances after its last op at the terminal address. The counter wraps with no gap cycle.
- Read checking:
  - Expected data is the element's read background, replicated to WIDTH bits.
  - Compare happens in the cycle after `bist_re` using a registered expected value and address.
- Failure reporting:
  - Any mismatch sets `fail`.
  - `fail_addr` latches only on the first mismatch of a run.
- FLUSH is one cycle with no strobes. It compares the final M5 read.
- On DONE entry: `Nbart`=0, `busy`=0, `done`=1.
- `start` while `busy`=1 is ignored.
- `start` in IDLE or DONE clears `done`, `fail` and `fail_addr` and begins M0.

## Timing
- Reset values: `Nbart`, `bist_addr`, `bist_wdata`, `bist_we`, `bist_re`, `busy`, `done`, `fail`, `fail_addr` all 0; state IDLE.
- Start of a run (`start` sampled at edge k):
  - From cycle k+1: `Nbart`=`busy`=1, `bist_we`=1, `bist_addr`=0, `bist_wdata`=0.
- Run length:
  - Active cycles total 10·DEPTH.
  - FLUSH occupies cycle k+1+10·DEPTH.
  - `done` rises at cycle k+2+10·DEPTH.
- Strobe rules:
  - `bist_we` and `bist_re` are never both 1.
  - Both are 0 whenever `Nbart`=0.
- `mem_rdata` is sampled at the edge ending the cycle after the read. A mismatch flags `fail` one cycle later.
- Asynchronous `rst` mid-run returns every output to its reset value immediately. The memory contents are left undefined, and no partial result is reported.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mbist_pkg` holds:
  - `march_state_t` enum (IDLE, M0–M5, FLUSH, DONE)
  - `march_op_t` enum (OP_R, OP_W)
  - per-element constants: direction, read background, write background, ops per address
- Sub-module `march_addr_gen`:
  - up/down ADDR_W counter with load-to-first-address and terminal-count outputs
  - the controller instantiates it once

## Test plan
- Fault-free memory model, ADDR_W=4, WIDTH=10, `start` pulse:
  - `busy`=1 for exactly 161 cycles
  - `done`=1, `fail`=0, `fail_addr`=0
  - first cycle writes 0 to address 0
- Stuck-at-1 on bit 3 of address 5:
  - `fail`=1, `fail_addr`=5
  - first failing read is in M1
- Faults injected at addresses 9 and 2 (both stuck-at-0 bit 0):
  - `fail_addr`=2 (first encountered, in M2 ascending), not 9
- Assert `rst` at cycle 50 of a run:
  - all outputs 0 immediately
  - new `start` produces a full clean pass with `done` after 161 cycles
- `start` pulsed at cycles 3 and 80 of a run:
  - ignored; run length unchanged
  - `start` after `done` reruns and clears a prior `fail`
- Strobe/address check over a full run:
  - `bist_we`&`bist_re` never both 1
  - M3 first read at address 15 with expected 0
